// File: rtl/textbuf_pkg.sv
// Shared ASCII constants, FSM state type and character classification for the text buffer.
package textbuf_pkg;

  localparam logic [6:0] CHR_SPACE = 7'h20;
  localparam logic [6:0] CHR_BS    = 7'h08;
  localparam logic [6:0] CHR_LF    = 7'h0A;
  localparam logic [6:0] CHR_CR    = 7'h0D;
  localparam logic [6:0] CHR_FF    = 7'h0C;
  localparam logic [6:0] CHR_TILDE = 7'h7E;

  typedef enum logic [1:0] {CLEAR, IDLE, CLR_ROW} tb_state_t;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= CHR_SPACE) && (c <= CHR_TILDE);
  endfunction

endpackage

// File: rtl/char_ram.sv
// Simple dual-port character cell RAM: one synchronous write port, one registered
// read-first read port, shaped so synthesis maps it onto block RAM.
module char_ram #(
  parameter int DEPTH = 3600,
  parameter int AW    = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [6:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [6:0]    rdata_o
);

  logic [6:0] mem [DEPTH];

  // Both accesses share one clock edge, so a same-cell read sees the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/text_buffer_writer.sv
// Character-cell text buffer: consumes an ASCII stream at a cursor and serves cells to the
// glyph renderer. Define TEXTBUF_SCROLL_EN to scroll at the bottom row instead of wrapping.
module text_buffer_writer
  import textbuf_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 45
) (
  input  logic                      pix_clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [6:0]                in_char,
  output logic                      in_ready,
  input  logic [11:0]               i_x,
  input  logic [11:0]               i_y,
  output logic [6:0]                character,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic                      busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [RW:0] ROWS_X = (RW+1)'(ROWS);

  // Screen row plus scroll offset, folded back into 0..ROWS-1 with one subtraction.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row,
                                              input logic [CW-1:0] col,
                                              input logic [RW-1:0] off);
    logic [RW:0] sum;
    logic [RW:0] prow;
    sum  = {1'b0, row} + {1'b0, off};
    prow = (sum >= ROWS_X) ? sum - ROWS_X : sum;
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  tb_state_t     state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [RW-1:0] offset;
  logic          oor_q, oor_d;
  logic          we, adv;
  logic [AW-1:0] waddr, raddr;
  logic [6:0]    wdata, rdata;
  logic [7:0]    col_r, row_r;
  logic          unused_pix;

`ifdef TEXTBUF_SCROLL_EN
  logic [RW-1:0] offset_q, offset_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign offset = offset_q;
`else
  assign offset = '0;
`endif

  assign col_r      = i_x[11:4];
  assign row_r      = i_y[11:4];
  assign unused_pix = ^{i_x[3:0], i_y[3:0]};
  assign oor_d      = (col_r >= 8'(COLS)) || (row_r >= 8'(ROWS));
  assign raddr      = oor_d ? '0 : cell_addr(row_r[RW-1:0], col_r[CW-1:0], offset);

  char_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (pix_clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // oor_q resets high so the character output reads 0 before the RAM holds anything.
  assign character  = oor_q ? 7'h00 : rdata;
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      col_q   <= '0;
      row_q   <= '0;
      sweep_q <= '0;
      oor_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sweep_q <= sweep_d;
      oor_q   <= oor_d;
    end
  end

`ifdef TEXTBUF_SCROLL_EN
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      cnt_q    <= '0;
    end else begin
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  // sweep_q doubles as the write address for both the full clear and the row clear.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sweep_d = sweep_q;
    we      = 1'b0;
    waddr   = sweep_q;
    wdata   = CHR_SPACE;
    adv     = 1'b0;
`ifdef TEXTBUF_SCROLL_EN
    offset_d = offset_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      CLEAR: begin
        we = 1'b1;
        if (sweep_q == AW'(DEPTH-1)) begin
          state_d = IDLE;
          sweep_d = '0;
          col_d   = '0;
          row_d   = '0;
`ifdef TEXTBUF_SCROLL_EN
          offset_d = '0;
`endif
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_char)) begin
            we    = 1'b1;
            waddr = cell_addr(row_q, col_q, offset);
            wdata = in_char;
            if (col_q == CW'(COLS-1)) begin
              col_d = '0;
              adv   = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (in_char)
              CHR_LF, CHR_CR: begin
                col_d = '0;
                adv   = 1'b1;
              end
              CHR_BS: begin
                if (col_q != '0) begin
                  col_d = col_q - 1'b1;
                  we    = 1'b1;
                  waddr = cell_addr(row_q, col_q - 1'b1, offset);
                end else if (row_q != '0) begin
                  row_d = row_q - 1'b1;
                  col_d = CW'(COLS-1);
                  we    = 1'b1;
                  waddr = cell_addr(row_q - 1'b1, CW'(COLS-1), offset);
                end
              end
              CHR_FF: begin
                state_d = CLEAR;
                sweep_d = '0;
              end
              default: ;
            endcase
          end
          // The new bottom row after a scroll is the physical row the old top occupied.
          if (adv) begin
            if (row_q != RW'(ROWS-1)) begin
              row_d = row_q + 1'b1;
            end else begin
`ifdef TEXTBUF_SCROLL_EN
              offset_d = (offset_q == RW'(ROWS-1)) ? '0 : offset_q + 1'b1;
              sweep_d  = cell_addr('0, '0, offset_q);
              cnt_d    = '0;
              state_d  = CLR_ROW;
`else
              row_d = '0;
`endif
            end
          end
        end
      end
`ifdef TEXTBUF_SCROLL_EN
      CLR_ROW: begin
        we      = 1'b1;
        sweep_d = sweep_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(COLS-1)) begin
          state_d = IDLE;
          sweep_d = '0;
        end
      end
`endif
      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer: random ASCII stream against a 2-D screen model,
// cell reads checked by a decoupled monitor. Honours TEXTBUF_SCROLL_EN like the design.
module tb_text_buffer_writer;
  import textbuf_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 45;
  localparam int LIMIT = 5000;
`ifdef TEXTBUF_SCROLL_EN
  localparam int LF_STALL = 80;
`else
  localparam int LF_STALL = 0;
`endif

  typedef struct {
    int         x;
    int         y;
    logic [6:0] exp;
  } probe_t;

  logic        pixClk = 1'b0;
  logic        rstN = 1'b0;
  logic        inValid = 1'b0;
  logic [6:0]  inChar = 7'h00;
  logic [11:0] iX = '0;
  logic [11:0] iY = '0;
  logic        inReady, busy;
  logic [6:0]  character;
  logic [6:0]  cursorCol;
  logic [5:0]  cursorRow;

  logic [6:0] screen [ROWS][COLS];
  int         curRow, curCol;
  probe_t     expQ[$];
  logic       probeEn = 1'b0;
  logic       probeSeen = 1'b0;
  int         assertCount = 0;
  int         failCount = 0;

  text_buffer_writer dut (
    .pix_clk    (pixClk),
    .rst_n      (rstN),
    .in_valid   (inValid),
    .in_char    (inChar),
    .in_ready   (inReady),
    .i_x        (iX),
    .i_y        (iY),
    .character  (character),
    .cursor_col (cursorCol),
    .cursor_row (cursorRow),
    .busy       (busy)
  );

  initial forever #5 pixClk = ~pixClk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: screen rows as the viewer sees them, scrolling by moving whole rows.
  function automatic void modelClear();
    foreach (screen[r, c]) screen[r][c] = 7'h20;
    curRow = 0;
    curCol = 0;
  endfunction

  function automatic void modelAdvance();
    if (curRow < ROWS-1) begin
      curRow++;
    end else begin
`ifdef TEXTBUF_SCROLL_EN
      for (int r = 0; r < ROWS-1; r++) screen[r] = screen[r+1];
      for (int c = 0; c < COLS; c++) screen[ROWS-1][c] = 7'h20;
`else
      curRow = 0;
`endif
    end
  endfunction

  function automatic void modelApply(input logic [6:0] ch);
    if (ch >= 7'h20 && ch <= 7'h7E) begin
      screen[curRow][curCol] = ch;
      if (curCol == COLS-1) begin
        curCol = 0;
        modelAdvance();
      end else begin
        curCol++;
      end
    end else if (ch == 7'h0A || ch == 7'h0D) begin
      curCol = 0;
      modelAdvance();
    end else if (ch == 7'h08) begin
      if (curCol > 0) begin
        curCol--;
        screen[curRow][curCol] = 7'h20;
      end else if (curRow > 0) begin
        curRow--;
        curCol = COLS-1;
        screen[curRow][curCol] = 7'h20;
      end
    end else if (ch == 7'h0C) begin
      modelClear();
    end
  endfunction

  function automatic logic [6:0] modelRead(input int x, input int y);
    if ((x / 16) >= COLS || (y / 16) >= ROWS) return 7'h00;
    return screen[y / 16][x / 16];
  endfunction

  // Sends one code; stall counts cycles with in_ready low after the handshake.
  task automatic applyStimulus(input logic [6:0] ch, input bit waitDone, output int stall);
    int w = 0;
    stall = 0;
    @(negedge pixClk);
    while (!inReady && w < LIMIT) begin
      @(negedge pixClk);
      w++;
    end
    if (!inReady) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    inValid = 1'b1;
    inChar  = ch;
    @(posedge pixClk);
    #1;
    inValid = 1'b0;
    modelApply(ch);
    if (waitDone) begin
      while (!inReady && stall < LIMIT) begin
        @(posedge pixClk);
        #1;
        stall++;
      end
    end
  endtask

  task automatic probeCell(input int x, input int y);
    probe_t p;
    @(negedge pixClk);
    iX = 12'(x);
    iY = 12'(y);
    p.x = x;
    p.y = y;
    p.exp = modelRead(x, y);
    expQ.push_back(p);
    probeEn = 1'b1;
  endtask

  task automatic probeEnd();
    @(negedge pixClk);
    probeEn = 1'b0;
  endtask

  task automatic scanAll();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        probeCell(c * 16 + int'($urandom_range(0, 15)), r * 16 + int'($urandom_range(0, 15)));
    probeEnd();
  endtask

  task automatic resetAndClear(input string tag);
    int n = 0;
    @(negedge pixClk);
    #2 rstN = 1'b0;
    #1;
    checkOutput({tag, "_rst_ready"}, inReady, 0);
    checkOutput({tag, "_rst_busy"}, busy, 1);
    checkOutput({tag, "_rst_char"}, character, 0);
    checkOutput({tag, "_rst_col"}, cursorCol, 0);
    checkOutput({tag, "_rst_row"}, cursorRow, 0);
    repeat (2) @(negedge pixClk);
    rstN = 1'b1;
    modelClear();
    do begin
      @(posedge pixClk);
      #1;
      n++;
    end while (!inReady && n < LIMIT);
    checkOutput({tag, "_clear_cycles"}, n, ROWS * COLS);
    checkOutput({tag, "_idle_busy"}, busy, 0);
  endtask

  // Monitor: each probe issued before a clock edge is compared on the following negedge.
  always @(posedge pixClk) probeSeen <= probeEn;

  always @(negedge pixClk) begin : monitor
    probe_t e;
    if (probeSeen) begin
      if (expQ.size() == 0) begin
        checkOutput("cell_unexpected", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput($sformatf("cell x=%0d y=%0d", e.x, e.y), character, e.exp);
      end
    end
  end

  initial begin : stimulus
    int   st;
    logic [6:0] ch;
    logic [6:0] others [4];
    others[0] = 7'h00; others[1] = 7'h01; others[2] = 7'h1B; others[3] = 7'h7F;

    resetAndClear("por");
    scanAll();

    applyStimulus(7'h31, 1'b1, st);
    applyStimulus(7'h2B, 1'b1, st);
    applyStimulus(7'h32, 1'b1, st);
    checkOutput("print_stall", st, 0);
    probeCell(0, 0);
    probeCell(16, 0);
    probeCell(32, 0);
    probeEnd();
    checkOutput("c3_col", cursorCol, 3);
    checkOutput("c3_row", cursorRow, 0);

    for (int i = 0; i < 77; i++) applyStimulus(7'($urandom_range(32, 126)), 1'b1, st);
    checkOutput("wrap_col", cursorCol, 0);
    checkOutput("wrap_row", cursorRow, 1);
    applyStimulus(7'h41, 1'b1, st);
    checkOutput("a_col", cursorCol, 1);
    checkOutput("a_row", cursorRow, 1);
    probeCell(0, 16);
    probeCell(79 * 16, 0);
    probeEnd();
    applyStimulus(CHR_BS, 1'b1, st);
    applyStimulus(CHR_BS, 1'b1, st);
    checkOutput("bs_col", cursorCol, 79);
    checkOutput("bs_row", cursorRow, 0);
    probeCell(79 * 16 + 5, 3);
    probeCell(0, 16);
    probeEnd();

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        6: ch = CHR_LF;
        7: ch = CHR_CR;
        8: ch = CHR_BS;
        9: ch = others[$urandom_range(0, 3)];
        default: ch = 7'($urandom_range(32, 126));
      endcase
      applyStimulus(ch, 1'b1, st);
    end
    checkOutput("mix_col", cursorCol, curCol);
    checkOutput("mix_row", cursorRow, curRow);
    for (int i = 0; i < 150; i++) probeCell(int'($urandom_range(0, 1400)), int'($urandom_range(0, 800)));
    probeCell(1280, 0);
    probeCell(0, 720);
    probeCell(4095, 4095);
    probeCell(1279, 719);
    probeEnd();

    applyStimulus(CHR_FF, 1'b1, st);
    checkOutput("ff_stall", st, ROWS * COLS);
    checkOutput("ff_col", cursorCol, 0);
    checkOutput("ff_row", cursorRow, 0);
    applyStimulus(CHR_BS, 1'b1, st);
    checkOutput("bs_home_col", cursorCol, 0);
    checkOutput("bs_home_row", cursorRow, 0);
    scanAll();

    for (int i = 0; i < ROWS * COLS - 1; i++) applyStimulus(7'($urandom_range(32, 126)), 1'b1, st);
    checkOutput("fill_col", cursorCol, COLS - 1);
    checkOutput("fill_row", cursorRow, ROWS - 1);
    applyStimulus(CHR_LF, 1'b1, st);
    checkOutput("lf_stall", st, LF_STALL);
    checkOutput("lf_col", cursorCol, curCol);
    checkOutput("lf_row", cursorRow, curRow);
    scanAll();

    applyStimulus(7'h78, 1'b1, st);
    applyStimulus(7'h79, 1'b1, st);
    applyStimulus(CHR_FF, 1'b0, st);
    repeat (1000) @(posedge pixClk);
    resetAndClear("mid");
    scanAll();

    repeat (3) @(negedge pixClk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
